// File: rtl/wb_pkg.sv
// Shared types and sizing for the writeback stage: data width, register count
// and the request record carried through the load queue.
package wb_pkg;
    localparam int XLEN     = 32;
    localparam int NREG     = 32;
    localparam int REG_AW   = $clog2(NREG);
    localparam int LQ_DEPTH = 2;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_req_t;
endpackage

// File: rtl/wb_fifo.sv
// Small load-result queue: power-of-two depth, head visible combinationally,
// pointers wrap naturally, synchronous active-low reset.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = LQ_DEPTH
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    push,
    input  logic    pop,
    input  wb_req_t push_data,
    output logic    full,
    output logic    empty,
    output wb_req_t head
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    wb_req_t         r_mem [DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [PW:0]     r_count;
    logic            w_push;
    logic            w_pop;

    assign full   = (r_count == (PW+1)'(DEPTH));
    assign empty  = (r_count == {(PW+1){1'b0}});
    assign head   = r_mem[r_rd_ptr];
    // Guards keep a misbehaving arbiter from corrupting the count.
    assign w_push = push & ~full;
    assign w_pop  = pop & ~empty;

    // Pointer, count and storage update.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= {PW{1'b0}};
            r_rd_ptr <= {PW{1'b0}};
            r_count  <= {(PW+1){1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= r_wr_ptr + {{(PW-1){1'b0}}, 1'b1};
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + {{(PW-1){1'b0}}, 1'b1};
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + {{PW{1'b0}}, 1'b1};
                2'b01:   r_count <= r_count - {{PW{1'b0}}, 1'b1};
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/writeback_unit.sv
// Writeback stage: arbitrates ALU and load results onto the single bank write
// port, queues colliding loads, and tracks busy registers for hazard checks.
module writeback_unit
    import wb_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [REG_AW-1:0] alu_rd,
    input  logic [XLEN-1:0]   alu_data,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [REG_AW-1:0] ld_rd,
    input  logic [XLEN-1:0]   ld_data,
    input  logic              iss_valid,
    input  logic [REG_AW-1:0] iss_rd,
    input  logic [REG_AW-1:0] rs1,
    input  logic [REG_AW-1:0] rs2,
    output logic              rs1_busy,
    output logic              rs2_busy,
    output logic [REG_AW-1:0] rd,
    output logic [XLEN-1:0]   write_data,
    output logic              reg_write
);
    logic              w_full;
    logic              w_empty;
    wb_req_t           w_head;
    logic              w_push;
    logic              w_pop;
    logic              w_sel_valid;
    wb_req_t           w_sel;
    wb_req_t           w_ld_req;
    logic [NREG-1:0]   w_busy_nxt;
    logic [NREG-1:0]   r_busy;
    logic [REG_AW-1:0] r_rd;
    logic [XLEN-1:0]   r_data;
    logic              r_reg_write;

    assign w_ld_req = '{rd: ld_rd, data: ld_data};

    wb_fifo #(.DEPTH(LQ_DEPTH)) u_lq (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_push),
        .pop       (w_pop),
        .push_data (w_ld_req),
        .full      (w_full),
        .empty     (w_empty),
        .head      (w_head)
    );

    assign alu_ready  = ~w_full;
    assign ld_ready   = ~w_full;
    assign rd         = r_rd;
    assign write_data = r_data;
    assign reg_write  = r_reg_write;
    assign rs1_busy   = r_busy[rs1];
    assign rs2_busy   = r_busy[rs2];

    // Priority arbiter: drain a full queue, then ALU, then queued loads, then bypass.
    always_comb begin
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_sel_valid = 1'b0;
        w_sel       = '0;
        if (w_full) begin
            w_pop       = 1'b1;
            w_sel_valid = 1'b1;
            w_sel       = w_head;
        end else if (alu_valid) begin
            w_sel_valid = 1'b1;
            w_sel       = '{rd: alu_rd, data: alu_data};
            w_push      = ld_valid;
        end else if (!w_empty) begin
            w_pop       = 1'b1;
            w_sel_valid = 1'b1;
            w_sel       = w_head;
            w_push      = ld_valid;
        end else if (ld_valid) begin
            w_sel_valid = 1'b1;
            w_sel       = w_ld_req;
        end else begin
            w_sel_valid = 1'b0;
        end
    end

    // Busy vector: commit clears first so a same-cycle issue wins.
    always_comb begin
        w_busy_nxt = r_busy;
        if (r_reg_write) begin
            w_busy_nxt[r_rd] = 1'b0;
        end else begin
            w_busy_nxt = r_busy;
        end
        if (iss_valid && (iss_rd != {REG_AW{1'b0}})) begin
            w_busy_nxt[iss_rd] = 1'b1;
        end else begin
            w_busy_nxt = w_busy_nxt;
        end
        w_busy_nxt[0] = 1'b0;
    end

    // Bank write port registers; x0 results are consumed without a write strobe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd        <= {REG_AW{1'b0}};
            r_data      <= {XLEN{1'b0}};
            r_reg_write <= 1'b0;
        end else if (w_sel_valid) begin
            r_rd        <= w_sel.rd;
            r_data      <= w_sel.data;
            r_reg_write <= (w_sel.rd != {REG_AW{1'b0}});
        end else begin
            r_reg_write <= 1'b0;
        end
    end

    // Scoreboard register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_busy <= {NREG{1'b0}};
        end else begin
            r_busy <= w_busy_nxt;
        end
    end
endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: reset, ALU/bypass paths, collisions,
// x0 handling, scoreboard set/clear and reset while the load queue is full.
module tb_writeback_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid, alu_ready, ld_valid, ld_ready, iss_valid;
    logic [4:0]  alu_rd, ld_rd, iss_rd, rs1, rs2, rd;
    logic [31:0] alu_data, ld_data, write_data;
    logic        rs1_busy, rs2_busy, reg_write;
    int          n_checks = 0;
    int          n_errors = 0;

    writeback_unit dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .rs1(rs1), .rs2(rs2),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .rd(rd), .write_data(write_data), .reg_write(reg_write)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        n_checks++; if (reg_write !== 1'b0) begin n_errors++; $display("FAIL reset_rw: got %b want 0", reg_write); end
        n_checks++; if (rd !== 5'd0) begin n_errors++; $display("FAIL reset_rd: got %0d want 0", rd); end
        n_checks++; if (write_data !== 32'd0) begin n_errors++; $display("FAIL reset_wd: got %h want 0", write_data); end
        n_checks++; if (alu_ready !== 1'b1) begin n_errors++; $display("FAIL reset_alu_ready: got %b want 1", alu_ready); end
        n_checks++; if (ld_ready !== 1'b1) begin n_errors++; $display("FAIL reset_ld_ready: got %b want 1", ld_ready); end
        for (int i = 0; i < 32; i++) begin
            rs1 = 5'(i); rs2 = 5'(31 - i);
            #1;
            n_checks++; if (rs1_busy !== 1'b0 || rs2_busy !== 1'b0) begin
                n_errors++; $display("FAIL reset_busy[%0d]: got %b%b want 00", i, rs1_busy, rs2_busy);
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_alu_and_bypass();
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        step();
        alu_valid = 1'b0;
        n_checks++; if (reg_write !== 1'b1 || rd !== 5'd5 || write_data !== 32'hDEADBEEF) begin
            n_errors++; $display("FAIL alu_path: got rw=%b rd=%0d wd=%h want 1 5 deadbeef", reg_write, rd, write_data);
        end
        ld_valid = 1'b1; ld_rd = 5'd9; ld_data = 32'h1234;
        n_checks++; if (ld_ready !== 1'b1) begin n_errors++; $display("FAIL bypass_ready: got %b want 1", ld_ready); end
        step();
        ld_valid = 1'b0;
        n_checks++; if (reg_write !== 1'b1 || rd !== 5'd9 || write_data !== 32'h1234) begin
            n_errors++; $display("FAIL ld_bypass: got rw=%b rd=%0d wd=%h want 1 9 1234", reg_write, rd, write_data);
        end
        step();
        n_checks++; if (reg_write !== 1'b0 || rd !== 5'd9 || write_data !== 32'h1234) begin
            n_errors++; $display("FAIL idle_hold: got rw=%b rd=%0d wd=%h want 0 9 1234", reg_write, rd, write_data);
        end
    endtask

    task automatic test_collision();
        // Per cycle: ALU/load inputs, then expected write and readies after the edge.
        logic        t_av  [9] = '{1, 0, 0, 1, 1, 1, 1, 0, 0};
        logic [4:0]  t_ard [9] = '{3, 0, 0, 10, 11, 12, 12, 0, 0};
        logic        t_lv  [9] = '{1, 0, 0, 1, 1, 1, 1, 0, 0};
        logic [4:0]  t_lrd [9] = '{4, 0, 0, 20, 21, 22, 22, 0, 0};
        logic        t_rw  [9] = '{1, 1, 0, 1, 1, 1, 1, 1, 1};
        logic [4:0]  t_rd  [9] = '{3, 4, 4, 10, 11, 20, 12, 21, 22};
        logic [31:0] t_wd  [9] = '{32'hA, 32'hB, 32'hB, 32'h10, 32'h11, 32'h20, 32'h12, 32'h21, 32'h22};
        logic        t_rdy [9] = '{1, 1, 1, 1, 0, 1, 0, 1, 1};
        for (int c = 0; c < 9; c++) begin
            alu_valid = t_av[c]; alu_rd = t_ard[c];
            alu_data  = (c == 0) ? 32'hA : {27'd0, t_ard[c]} + 32'h6;
            ld_valid  = t_lv[c]; ld_rd = t_lrd[c];
            ld_data   = (c == 0) ? 32'hB : {27'd0, t_lrd[c]} + 32'hC;
            step();
            n_checks++; if (reg_write !== t_rw[c] || rd !== t_rd[c] || write_data !== t_wd[c]) begin
                n_errors++; $display("FAIL collision[%0d]: got rw=%b rd=%0d wd=%h want %b %0d %h",
                                     c, reg_write, rd, write_data, t_rw[c], t_rd[c], t_wd[c]);
            end
            n_checks++; if (alu_ready !== t_rdy[c] || ld_ready !== t_rdy[c]) begin
                n_errors++; $display("FAIL collision_ready[%0d]: got alu=%b ld=%b want %b",
                                     c, alu_ready, ld_ready, t_rdy[c]);
            end
        end
        alu_valid = 1'b0; ld_valid = 1'b0;
        step();
        n_checks++; if (reg_write !== 1'b0) begin n_errors++; $display("FAIL drain_done: got rw=%b want 0", reg_write); end
    endtask

    task automatic test_x0();
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFF_FFFF;
        iss_valid = 1'b1; iss_rd = 5'd0; rs1 = 5'd0;
        step();
        alu_valid = 1'b0; iss_valid = 1'b0;
        n_checks++; if (reg_write !== 1'b0) begin n_errors++; $display("FAIL x0_rw: got %b want 0", reg_write); end
        n_checks++; if (rs1_busy !== 1'b0) begin n_errors++; $display("FAIL x0_busy: got %b want 0", rs1_busy); end
    endtask

    task automatic test_scoreboard();
        iss_valid = 1'b1; iss_rd = 5'd7; rs1 = 5'd7; rs2 = 5'd8;
        #1;
        n_checks++; if (rs1_busy !== 1'b0) begin n_errors++; $display("FAIL sb_pre: got %b want 0", rs1_busy); end
        step();
        iss_valid = 1'b0;
        n_checks++; if (rs1_busy !== 1'b1 || rs2_busy !== 1'b0) begin
            n_errors++; $display("FAIL sb_set: got %b%b want 10", rs1_busy, rs2_busy);
        end
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h77;
        step();
        alu_valid = 1'b0;
        n_checks++; if (reg_write !== 1'b1 || rd !== 5'd7 || rs1_busy !== 1'b1) begin
            n_errors++; $display("FAIL sb_commit_cycle: got rw=%b rd=%0d busy=%b want 1 7 1", reg_write, rd, rs1_busy);
        end
        step();
        n_checks++; if (rs1_busy !== 1'b0) begin n_errors++; $display("FAIL sb_clear: got %b want 0", rs1_busy); end
        iss_valid = 1'b1;
        step();
        iss_valid = 1'b0; alu_valid = 1'b1; alu_data = 32'h78;
        step();
        alu_valid = 1'b0; iss_valid = 1'b1;
        step();
        iss_valid = 1'b0;
        n_checks++; if (rs1_busy !== 1'b1) begin n_errors++; $display("FAIL sb_set_wins: got %b want 1", rs1_busy); end
        step();
        n_checks++; if (rs1_busy !== 1'b1) begin n_errors++; $display("FAIL sb_set_holds: got %b want 1", rs1_busy); end
    endtask

    task automatic test_reset_mid_drain();
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h1;
        ld_valid  = 1'b1; ld_rd  = 5'd13; ld_data = 32'h13;
        iss_valid = 1'b1; iss_rd = 5'd15;
        step();
        iss_valid = 1'b0; alu_rd = 5'd2; alu_data = 32'h2; ld_rd = 5'd14; ld_data = 32'h14;
        step();
        alu_valid = 1'b0; ld_valid = 1'b0;
        n_checks++; if (ld_ready !== 1'b0) begin n_errors++; $display("FAIL mid_full: got ld_ready=%b want 0", ld_ready); end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        n_checks++; if (reg_write !== 1'b0 || rd !== 5'd0 || write_data !== 32'd0) begin
            n_errors++; $display("FAIL mid_reset_out: got rw=%b rd=%0d wd=%h want 0 0 0", reg_write, rd, write_data);
        end
        for (int c = 0; c < 3; c++) begin
            step();
            n_checks++; if (reg_write !== 1'b0 || ld_ready !== 1'b1) begin
                n_errors++; $display("FAIL mid_after[%0d]: got rw=%b ld_ready=%b want 0 1", c, reg_write, ld_ready);
            end
        end
        for (int i = 0; i < 32; i++) begin
            rs1 = 5'(i); rs2 = 5'(i);
            #1;
            n_checks++; if (rs1_busy !== 1'b0 || rs2_busy !== 1'b0) begin
                n_errors++; $display("FAIL mid_busy[%0d]: got %b%b want 00", i, rs1_busy, rs2_busy);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
        ld_valid = 1'b0; ld_rd = 5'd0; ld_data = 32'd0;
        iss_valid = 1'b0; iss_rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
        step();
        test_reset();
        test_alu_and_bypass();
        test_collision();
        test_x0();
        test_scoreboard();
        test_reset_mid_drain();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
